// File: rtl/core_if_prefetch.sv
// core_if_prefetch
//   Instruction-fetch stage with a small prefetch queue. When it holds the ROM bus
//   it issues one req/ack fetch at a time, stores each returned {address, word}
//   pair, and hands the oldest pair to decode through a valid/ready handshake.
//   A redirect (flush) empties the queue, moves the fetch address, and discards
//   any fetch that is still in flight.
//
// Ports
//   clk            rising-edge clock
//   rst_n          synchronous reset, active low
//   bus_grant_in   1 = this block owns the ROM bus
//   rom_req_out    fetch request, held with rom_addr_out until rom_ack_in
//   rom_addr_out   fetch word address
//   rom_ack_in     fetch response valid, rom_data_in valid in the same cycle
//   rom_data_in    fetched word
//   flush_in       redirect: discard queued and in-flight words
//   flush_addr_in  new fetch address, taken when flush_in = 1
//   id_ready_in    decode takes the head entry this cycle
//   inst_valid_out head entry valid
//   inst_addr_out  head entry address (0 when empty)
//   inst_out       head entry instruction (0 when empty)
//   q_count_out    queue occupancy
module core_if_prefetch #(
   parameter int                ADDR_W   = 32,
   parameter int                DATA_W   = 32,
   parameter int                DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int                PC_STEP  = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       bus_grant_in,
   output logic                       rom_req_out,
   output logic [ADDR_W-1:0]          rom_addr_out,
   input  logic                       rom_ack_in,
   input  logic [DATA_W-1:0]          rom_data_in,
   input  logic                       flush_in,
   input  logic [ADDR_W-1:0]          flush_addr_in,
   input  logic                       id_ready_in,
   output logic                       inst_valid_out,
   output logic [ADDR_W-1:0]          inst_addr_out,
   output logic [DATA_W-1:0]          inst_out,
   output logic [$clog2(DEPTH):0]     q_count_out
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0]     DEPTH_C = CW'(DEPTH);
   localparam logic [ADDR_W-1:0] STEP_C  = ADDR_W'(PC_STEP);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t              state_reg;
   logic [ADDR_W-1:0]   fetch_pc_reg;
   logic                rom_req_reg;
   logic [ADDR_W-1:0]   rom_addr_reg;
   logic                drop_reg;
   logic [PW-1:0]       wr_ptr_reg;
   logic [PW-1:0]       rd_ptr_reg;
   logic [CW-1:0]       count_reg;

   logic [ADDR_W-1:0]   addr_mem [DEPTH];
   logic [DATA_W-1:0]   data_mem [DEPTH];

   logic                ack_take;
   logic                push;
   logic                pop;
   logic [CW-1:0]       count_next;
   logic                room;
   logic [ADDR_W-1:0]   pc_inc;

   // A response is only meaningful while a request is outstanding.
   assign ack_take   = (state_reg == BUSY) && rom_ack_in;
   // The word answering a request that was overtaken by a flush is never stored.
   assign push       = ack_take && !flush_in && !drop_reg;
   assign pop        = (count_reg != '0) && id_ready_in && !flush_in;
   assign count_next = flush_in ? '0 : (count_reg + CW'(push) - CW'(pop));
   // Only start a fetch when its word is guaranteed a free slot.
   assign room       = (count_next < DEPTH_C);
   assign pc_inc     = fetch_pc_reg + STEP_C;

   // Queue storage carries no reset; only the pointers and count define contents.
   always_ff @(posedge clk) begin
      if (push) begin
         addr_mem[wr_ptr_reg] <= rom_addr_reg;
         data_mem[wr_ptr_reg] <= rom_data_in;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         fetch_pc_reg <= RESET_PC;
         rom_req_reg  <= 1'b0;
         rom_addr_reg <= '0;
         drop_reg     <= 1'b0;
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
      end else begin
         // Queue bookkeeping
         count_reg <= count_next;
         if (flush_in) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
         end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
         end

         // Request FSM
         case (state_reg)
            IDLE: begin
               if (flush_in) begin
                  fetch_pc_reg <= flush_addr_in;
               end else if (bus_grant_in && room) begin
                  state_reg    <= BUSY;
                  rom_req_reg  <= 1'b1;
                  rom_addr_reg <= fetch_pc_reg;
               end
            end
            BUSY: begin
               if (flush_in) begin
                  fetch_pc_reg <= flush_addr_in;
                  if (rom_ack_in) begin
                     state_reg   <= IDLE;
                     rom_req_reg <= 1'b0;
                     drop_reg    <= 1'b0;
                  end else begin
                     // Keep the bus transaction alive but mark its answer stale.
                     drop_reg <= 1'b1;
                  end
               end else if (rom_ack_in) begin
                  if (drop_reg) begin
                     // Stale answer consumed; restart cleanly from IDLE.
                     drop_reg    <= 1'b0;
                     state_reg   <= IDLE;
                     rom_req_reg <= 1'b0;
                  end else begin
                     fetch_pc_reg <= pc_inc;
                     if (bus_grant_in && room) begin
                        rom_addr_reg <= pc_inc;
                     end else begin
                        state_reg   <= IDLE;
                        rom_req_reg <= 1'b0;
                     end
                  end
               end
            end
            default: begin
               state_reg   <= IDLE;
               rom_req_reg <= 1'b0;
            end
         endcase
      end
   end

   assign rom_req_out    = rom_req_reg;
   assign rom_addr_out   = rom_addr_reg;
   assign inst_valid_out = (count_reg != '0);
   assign inst_addr_out  = inst_valid_out ? addr_mem[rd_ptr_reg] : '0;
   assign inst_out       = inst_valid_out ? data_mem[rd_ptr_reg] : '0;
   assign q_count_out    = count_reg;

endmodule

// File: tb/tb_core_if_prefetch.sv
// Testbench for core_if_prefetch: directed scenarios with hand-computed expectations.
module tb_core_if_prefetch;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        bus_grant_in;
   logic        rom_req_out;
   logic [31:0] rom_addr_out;
   logic        rom_ack_in;
   logic [31:0] rom_data_in;
   logic        flush_in;
   logic [31:0] flush_addr_in;
   logic        id_ready_in;
   logic        inst_valid_out;
   logic [31:0] inst_addr_out;
   logic [31:0] inst_out;
   logic [2:0]  q_count_out;

   // Second instance for the address-wrap scenario (always granted, zero-wait ROM).
   logic        rst2_n;
   logic        req2;
   logic [31:0] addr2;
   logic        valid2;
   logic [31:0] iaddr2;
   logic [31:0] inst2;
   logic [2:0]  count2;

   int checks = 0;
   int errors = 0;

   // ROM model
   bit ack_en;
   int ack_wait;
   int wait_cnt = 0;

   function automatic logic [31:0] rom_word(input logic [31:0] a);
      return {a[15:0] ^ 16'hC3A5, a[31:16] ^ 16'h5A3C};
   endfunction

   assign rom_ack_in  = rom_req_out && ack_en && (wait_cnt >= ack_wait);
   assign rom_data_in = rom_word(rom_addr_out);

   always @(posedge clk) begin
      if (rom_req_out && !rom_ack_in) wait_cnt <= wait_cnt + 1;
      else                            wait_cnt <= 0;
   end

   always #5 clk = ~clk;

   core_if_prefetch #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .RESET_PC(32'h0), .PC_STEP(4)) dut (
      .clk(clk), .rst_n(rst_n), .bus_grant_in(bus_grant_in),
      .rom_req_out(rom_req_out), .rom_addr_out(rom_addr_out),
      .rom_ack_in(rom_ack_in), .rom_data_in(rom_data_in),
      .flush_in(flush_in), .flush_addr_in(flush_addr_in),
      .id_ready_in(id_ready_in), .inst_valid_out(inst_valid_out),
      .inst_addr_out(inst_addr_out), .inst_out(inst_out),
      .q_count_out(q_count_out)
   );

   core_if_prefetch #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8), .PC_STEP(4)) dut_w (
      .clk(clk), .rst_n(rst2_n), .bus_grant_in(1'b1),
      .rom_req_out(req2), .rom_addr_out(addr2),
      .rom_ack_in(req2), .rom_data_in(rom_word(addr2)),
      .flush_in(1'b0), .flush_addr_in(32'h0),
      .id_ready_in(1'b1), .inst_valid_out(valid2),
      .inst_addr_out(iaddr2), .inst_out(inst2),
      .q_count_out(count2)
   );

   // One line per accepted instruction.
   always @(posedge clk) begin
      if (rst_n && inst_valid_out && id_ready_in && !flush_in)
         $display("pop   addr=%h inst=%h count=%0d", inst_addr_out, inst_out, q_count_out);
   end

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0; bus_grant_in = 1'b0; flush_in = 1'b0; flush_addr_in = 32'h0;
      id_ready_in = 1'b0; ack_en = 1'b1; ack_wait = 0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      apply_reset();
      checks++; if (rom_req_out !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", rom_req_out); end
      checks++; if (rom_addr_out !== 32'h0) begin errors++; $display("FAIL reset_addr got=%h exp=0", rom_addr_out); end
      checks++; if (inst_valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", inst_valid_out); end
      checks++; if (inst_addr_out !== 32'h0) begin errors++; $display("FAIL reset_iaddr got=%h exp=0", inst_addr_out); end
      checks++; if (inst_out !== 32'h0) begin errors++; $display("FAIL reset_inst got=%h exp=0", inst_out); end
      checks++; if (q_count_out !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", q_count_out); end
      // Reset must win over grant, flush and ready.
      bus_grant_in = 1'b1; id_ready_in = 1'b1; flush_in = 1'b1; flush_addr_in = 32'h40;
      @(negedge clk);
      checks++; if (rom_req_out !== 1'b0) begin errors++; $display("FAIL reset_override_req got=%b exp=0", rom_req_out); end
      flush_in = 1'b0;
   endtask

   task automatic test_stream();
      logic [31:0] e;
      apply_reset();
      bus_grant_in = 1'b1; id_ready_in = 1'b1; rst_n = 1'b1;
      @(negedge clk);
      checks++; if (rom_req_out !== 1'b1 || rom_addr_out !== 32'h0)
         begin errors++; $display("FAIL stream_first_req got=%b/%h exp=1/00000000", rom_req_out, rom_addr_out); end
      checks++; if (inst_valid_out !== 1'b0) begin errors++; $display("FAIL stream_valid_c1 got=%b exp=0", inst_valid_out); end
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         e = 32'(4 * k);
         checks++; if (inst_valid_out !== 1'b1 || inst_addr_out !== e)
            begin errors++; $display("FAIL stream_head k=%0d got=%b/%h exp=1/%h", k, inst_valid_out, inst_addr_out, e); end
         checks++; if (inst_out !== rom_word(e))
            begin errors++; $display("FAIL stream_inst k=%0d got=%h exp=%h", k, inst_out, rom_word(e)); end
         checks++; if (rom_addr_out !== e + 32'd4)
            begin errors++; $display("FAIL stream_req_addr k=%0d got=%h exp=%h", k, rom_addr_out, e + 32'd4); end
      end
   endtask

   task automatic test_queue_full();
      apply_reset();
      bus_grant_in = 1'b1; id_ready_in = 1'b0; rst_n = 1'b1;
      repeat (5) @(negedge clk);
      checks++; if (q_count_out !== 3'd4) begin errors++; $display("FAIL full_count got=%0d exp=4", q_count_out); end
      checks++; if (rom_req_out !== 1'b0) begin errors++; $display("FAIL full_req got=%b exp=0", rom_req_out); end
      checks++; if (inst_addr_out !== 32'h0) begin errors++; $display("FAIL full_head got=%h exp=0", inst_addr_out); end
      @(negedge clk);
      checks++; if (rom_req_out !== 1'b0 || q_count_out !== 3'd4)
         begin errors++; $display("FAIL full_hold got=%b/%0d exp=0/4", rom_req_out, q_count_out); end
      id_ready_in = 1'b1;
      @(negedge clk);
      id_ready_in = 1'b0;
      checks++; if (q_count_out !== 3'd3) begin errors++; $display("FAIL pop_count got=%0d exp=3", q_count_out); end
      checks++; if (rom_req_out !== 1'b1 || rom_addr_out !== 32'h10)
         begin errors++; $display("FAIL reissue_req got=%b/%h exp=1/00000010", rom_req_out, rom_addr_out); end
      checks++; if (inst_addr_out !== 32'h4) begin errors++; $display("FAIL pop_head got=%h exp=4", inst_addr_out); end
      @(negedge clk);
      checks++; if (q_count_out !== 3'd4 || rom_req_out !== 1'b0)
         begin errors++; $display("FAIL refill got=%0d/%b exp=4/0", q_count_out, rom_req_out); end
   endtask

   task automatic test_flush_busy();
      bit found;
      bit bad_valid;
      bit seen_low;
      apply_reset();
      ack_wait = 3; bus_grant_in = 1'b1; id_ready_in = 1'b0; rst_n = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         if (rom_req_out && rom_addr_out == 32'h8) found = 1'b1;
      end
      checks++; if (!found) begin errors++; $display("FAIL flush_busy_reach got=timeout exp=req@8"); end
      checks++; if (q_count_out !== 3'd2) begin errors++; $display("FAIL flush_busy_pre_count got=%0d exp=2", q_count_out); end
      flush_in = 1'b1; flush_addr_in = 32'h100;
      @(negedge clk);
      flush_in = 1'b0;
      checks++; if (q_count_out !== 3'd0 || inst_valid_out !== 1'b0)
         begin errors++; $display("FAIL flush_busy_empty got=%0d/%b exp=0/0", q_count_out, inst_valid_out); end
      checks++; if (rom_req_out !== 1'b1 || rom_addr_out !== 32'h8)
         begin errors++; $display("FAIL flush_busy_hold got=%b/%h exp=1/00000008", rom_req_out, rom_addr_out); end
      found = 1'b0; bad_valid = 1'b0; seen_low = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         if (inst_valid_out) bad_valid = 1'b1;
         if (!rom_req_out) seen_low = 1'b1;
         if (rom_req_out && rom_addr_out == 32'h100) found = 1'b1;
      end
      checks++; if (!found) begin errors++; $display("FAIL flush_busy_newreq got=timeout exp=req@100"); end
      checks++; if (bad_valid) begin errors++; $display("FAIL flush_busy_discard got=valid exp=no_valid"); end
      checks++; if (!seen_low) begin errors++; $display("FAIL flush_busy_idle got=no_idle exp=idle_gap"); end
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         if (inst_valid_out) found = 1'b1;
      end
      checks++; if (!found || inst_addr_out !== 32'h100 || inst_out !== rom_word(32'h100))
         begin errors++; $display("FAIL flush_busy_first got=%b/%h/%h exp=1/00000100/%h", found, inst_addr_out, inst_out, rom_word(32'h100)); end
   endtask

   task automatic test_flush_ack_pop();
      apply_reset();
      bus_grant_in = 1'b1; id_ready_in = 1'b0; rst_n = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (q_count_out !== 3'd2 || rom_ack_in !== 1'b1 || rom_addr_out !== 32'h8)
         begin errors++; $display("FAIL fap_setup got=%0d/%b/%h exp=2/1/00000008", q_count_out, rom_ack_in, rom_addr_out); end
      flush_in = 1'b1; flush_addr_in = 32'h200; id_ready_in = 1'b1;
      @(negedge clk);
      flush_in = 1'b0; id_ready_in = 1'b0;
      checks++; if (q_count_out !== 3'd0 || inst_valid_out !== 1'b0)
         begin errors++; $display("FAIL fap_empty got=%0d/%b exp=0/0", q_count_out, inst_valid_out); end
      checks++; if (rom_req_out !== 1'b0) begin errors++; $display("FAIL fap_idle got=%b exp=0", rom_req_out); end
      @(negedge clk);
      checks++; if (rom_req_out !== 1'b1 || rom_addr_out !== 32'h200)
         begin errors++; $display("FAIL fap_newreq got=%b/%h exp=1/00000200", rom_req_out, rom_addr_out); end
      @(negedge clk);
      checks++; if (q_count_out !== 3'd1 || inst_addr_out !== 32'h200 || inst_out !== rom_word(32'h200))
         begin errors++; $display("FAIL fap_first got=%0d/%h/%h exp=1/00000200/%h", q_count_out, inst_addr_out, inst_out, rom_word(32'h200)); end
   endtask

   task automatic test_grant_loss();
      apply_reset();
      ack_en = 1'b0; bus_grant_in = 1'b1; id_ready_in = 1'b0; rst_n = 1'b1;
      @(negedge clk);
      checks++; if (rom_req_out !== 1'b1 || rom_addr_out !== 32'h0)
         begin errors++; $display("FAIL grant_req got=%b/%h exp=1/00000000", rom_req_out, rom_addr_out); end
      bus_grant_in = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (rom_req_out !== 1'b1 || rom_addr_out !== 32'h0 || q_count_out !== 3'd0)
         begin errors++; $display("FAIL grant_hold got=%b/%h/%0d exp=1/00000000/0", rom_req_out, rom_addr_out, q_count_out); end
      ack_en = 1'b1;
      @(negedge clk);
      checks++; if (q_count_out !== 3'd1 || rom_req_out !== 1'b0 || inst_addr_out !== 32'h0 || inst_out !== rom_word(32'h0))
         begin errors++; $display("FAIL grant_ack got=%0d/%b/%h/%h exp=1/0/00000000/%h", q_count_out, rom_req_out, inst_addr_out, inst_out, rom_word(32'h0)); end
      repeat (2) @(negedge clk);
      checks++; if (rom_req_out !== 1'b0) begin errors++; $display("FAIL grant_idle got=%b exp=0", rom_req_out); end
      bus_grant_in = 1'b1;
      @(negedge clk);
      checks++; if (rom_req_out !== 1'b1 || rom_addr_out !== 32'h4)
         begin errors++; $display("FAIL grant_resume got=%b/%h exp=1/00000004", rom_req_out, rom_addr_out); end
   endtask

   task automatic test_wrap();
      @(negedge clk);
      rst2_n = 1'b1;
      @(negedge clk);
      checks++; if (req2 !== 1'b1 || addr2 !== 32'hFFFF_FFF8)
         begin errors++; $display("FAIL wrap_req0 got=%b/%h exp=1/fffffff8", req2, addr2); end
      @(negedge clk);
      checks++; if (addr2 !== 32'hFFFF_FFFC || valid2 !== 1'b1 || iaddr2 !== 32'hFFFF_FFF8 || inst2 !== rom_word(32'hFFFF_FFF8))
         begin errors++; $display("FAIL wrap_req1 got=%h/%b/%h/%h exp=fffffffc/1/fffffff8/%h", addr2, valid2, iaddr2, inst2, rom_word(32'hFFFF_FFF8)); end
      @(negedge clk);
      checks++; if (addr2 !== 32'h0 || iaddr2 !== 32'hFFFF_FFFC)
         begin errors++; $display("FAIL wrap_req2 got=%h/%h exp=00000000/fffffffc", addr2, iaddr2); end
      rst2_n = 1'b0;
      @(negedge clk);
      checks++; if (req2 !== 1'b0 || addr2 !== 32'h0 || valid2 !== 1'b0 || iaddr2 !== 32'h0 || inst2 !== 32'h0 || count2 !== 3'd0)
         begin errors++; $display("FAIL wrap_midreset got=%b/%h/%b/%h/%h/%0d exp=all_zero", req2, addr2, valid2, iaddr2, inst2, count2); end
   endtask

   initial begin
      rst_n = 1'b0; rst2_n = 1'b0; bus_grant_in = 1'b0; flush_in = 1'b0;
      flush_addr_in = 32'h0; id_ready_in = 1'b0; ack_en = 1'b1; ack_wait = 0;
      test_reset();
      test_stream();
      test_queue_full();
      test_flush_busy();
      test_flush_ack_pop();
      test_grant_loss();
      test_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
